player_mover: RTL and testbench

Parametrised player-object controller, successor to the fixed-size player wrapper. It owns the player sprite's position and life cycle on the 640x480 playfield: stepped moves from the button bank with auto-repeat, clamping to a configurable bounding box, collision-driven death, timed respawn and a game-over latch. Its outputs feed the sprite renderer and collision checker directly; all state advances on the slow button clock.

---
 rtl/player_mover.sv | 197 +++++++++++++++++++
 tb/tb_player_mover.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_mover.sv
// player_mover: owns the player sprite position, lives and alive/dead/game-over life cycle.
// Latency: one btnClk cycle from a sampled button/hit to the registered outputs.
// Backpressure: none; inputs are levels sampled every cycle, and outputs are always valid.
// Ports: btnClk/rst (sync, active-high); btns[3:0] = up/down/left/right, gated by *Enable;
//        hit = hazard collision; hPos/vPos = top-left corner; hOffset/vOffset = offset from spawn;
//        objWidth/objHeight = sprite size; color, lives, status = {blocked, dead, alive}.
module player_mover #(
  parameter int RECT_W        = 12,
  parameter int RECT_H        = 12,
  parameter int H_START       = 308,
  parameter int V_START       = 372,
  parameter int STEP          = 12,
  parameter int H_MIN         = 0,
  parameter int H_MAX         = 628,
  parameter int V_MIN         = 0,
  parameter int V_MAX         = 468,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_RATE   = 4,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 16,
  parameter logic [2:0] COLOR = 3'b100
) (
  input  logic        btnClk,
  input  logic        rst,
  input  logic [3:0]  btns,
  input  logic        upEnable,
  input  logic        downEnable,
  input  logic        leftEnable,
  input  logic        rightEnable,
  input  logic        hit,
  output logic [11:0] hPos,
  output logic [11:0] vPos,
  output logic [31:0] hOffset,
  output logic [31:0] vOffset,
  output logic [11:0] objWidth,
  output logic [11:0] objHeight,
  output logic [2:0]  color,
  output logic [2:0]  lives,
  output logic [2:0]  status
);

  typedef enum logic [1:0] {ALIVE, DEAD, GAMEOVER} stateT;

  localparam logic signed [13:0] STEP_S  = 14'(STEP);
  localparam logic signed [13:0] H_MIN_S = 14'(H_MIN);
  localparam logic signed [13:0] H_MAX_S = 14'(H_MAX);
  localparam logic signed [13:0] V_MIN_S = 14'(V_MIN);
  localparam logic signed [13:0] V_MAX_S = 14'(V_MAX);
  localparam logic [15:0] DELAY_M1 = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RATE_M1  = 16'(REPEAT_RATE - 1);

  stateT       state, stateNext;
  logic [3:0]  req, dir, prevDir;
  logic [15:0] repCnt, repCntNext;
  logic        repArmed, repArmedNext;
  logic [15:0] deadCnt, deadCntNext;
  logic [11:0] hNext, vNext, hMoved, vMoved;
  logic [2:0]  livesNext, colorNext, statusNext;
  logic [31:0] hOffNext, vOffNext;
  logic        blockedNext, hBlk, vBlk;
  logic        pressEdge, holding, repeatFire;
  logic signed [13:0] hTry, vTry;

  assign objWidth  = 12'(RECT_W);
  assign objHeight = 12'(RECT_H);

  // Lowest set request bit wins, so the active direction is always one-hot (or zero).
  assign req = btns & {rightEnable, leftEnable, downEnable, upEnable};
  assign dir = req & (~req + 4'd1);

  // prevDir tracks the active direction in every state, so a direction held across
  // reset or a respawn never looks like a fresh press.
  assign pressEdge  = (dir != 4'd0) && (dir != prevDir);
  assign holding    = (dir != 4'd0) && (dir == prevDir) && repArmed;
  assign repeatFire = holding && (repCnt == 16'd0);

  // Candidate step with clamping; 14-bit signed keeps underflow below zero visible.
  always_comb begin : moveCalc
    hTry = $signed({2'b00, hPos});
    vTry = $signed({2'b00, vPos});
    if (dir[0])      vTry = vTry - STEP_S;
    else if (dir[1]) vTry = vTry + STEP_S;
    else if (dir[2]) hTry = hTry - STEP_S;
    else if (dir[3]) hTry = hTry + STEP_S;

    hBlk = 1'b0;
    vBlk = 1'b0;
    if (hTry < H_MIN_S) begin
      hMoved = 12'(H_MIN);
      hBlk   = 1'b1;
    end else if (hTry > H_MAX_S) begin
      hMoved = 12'(H_MAX);
      hBlk   = 1'b1;
    end else begin
      hMoved = hTry[11:0];
    end
    if (vTry < V_MIN_S) begin
      vMoved = 12'(V_MIN);
      vBlk   = 1'b1;
    end else if (vTry > V_MAX_S) begin
      vMoved = 12'(V_MAX);
      vBlk   = 1'b1;
    end else begin
      vMoved = vTry[11:0];
    end
  end

  always_comb begin : nextState
    stateNext    = state;
    hNext        = hPos;
    vNext        = vPos;
    livesNext    = lives;
    deadCntNext  = deadCnt;
    repCntNext   = repCnt;
    repArmedNext = 1'b0;
    blockedNext  = 1'b0;
    case (state)
      ALIVE: begin
        if (hit) begin
          // A hit takes priority over any move requested in the same cycle.
          livesNext = lives - 3'd1;
          hNext     = 12'(H_START);
          vNext     = 12'(V_START);
          if (livesNext == 3'd0) begin
            stateNext = GAMEOVER;
          end else begin
            stateNext   = DEAD;
            deadCntNext = 16'(RESPAWN_TICKS);
          end
        end else if (pressEdge || repeatFire) begin
          hNext        = hMoved;
          vNext        = vMoved;
          blockedNext  = hBlk | vBlk;
          repArmedNext = 1'b1;
          repCntNext   = pressEdge ? DELAY_M1 : RATE_M1;
        end else if (holding) begin
          repArmedNext = 1'b1;
          repCntNext   = repCnt - 16'd1;
        end
      end
      DEAD: begin
        if (deadCnt <= 16'd1) begin
          stateNext   = ALIVE;
          deadCntNext = 16'd0;
        end else begin
          deadCntNext = deadCnt - 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin : outputDecode
    colorNext  = 3'b000;
    statusNext = 3'b000;
    case (stateNext)
      ALIVE: begin
        colorNext  = COLOR;
        statusNext = {blockedNext, 2'b01};
      end
      DEAD:    statusNext = 3'b010;
      default: ;
    endcase
    hOffNext = {20'd0, hNext} - 32'(H_START);
    vOffNext = {20'd0, vNext} - 32'(V_START);
  end

  always_ff @(posedge btnClk) begin : stateReg
    prevDir <= dir;
    if (rst) begin
      state    <= ALIVE;
      hPos     <= 12'(H_START);
      vPos     <= 12'(V_START);
      hOffset  <= 32'd0;
      vOffset  <= 32'd0;
      lives    <= 3'(LIVES);
      status   <= 3'b001;
      color    <= COLOR;
      repCnt   <= 16'd0;
      repArmed <= 1'b0;
      deadCnt  <= 16'd0;
    end else begin
      state    <= stateNext;
      hPos     <= hNext;
      vPos     <= vNext;
      hOffset  <= hOffNext;
      vOffset  <= vOffNext;
      lives    <= livesNext;
      status   <= statusNext;
      color    <= colorNext;
      repCnt   <= repCntNext;
      repArmed <= repArmedNext;
      deadCnt  <= deadCntNext;
    end
  end

endmodule

// File: tb/tb_player_mover.sv
module tb_player_mover;

  localparam int HS = 308;
  localparam int VS = 372;
  localparam int ST = 12;
  localparam int HMIN = 0;
  localparam int HMAX = 628;
  localparam int VMIN = 0;
  localparam int VMAX = 468;
  localparam int DLY = 8;
  localparam int RATE = 4;
  localparam int NLIVES = 3;
  localparam int RESP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btns = 4'd0;
  logic        upEn = 1'b1, downEn = 1'b1, leftEn = 1'b1, rightEn = 1'b1;
  logic        hit = 1'b0;
  logic [11:0] hPos, vPos, objWidth, objHeight;
  logic [31:0] hOffset, vOffset;
  logic [2:0]  color, lives, status;

  int nChecks = 0;
  int nFail = 0;

  // Reference model state: positions as plain ints, holdLen = cycles the current
  // direction has been held since its press (-1 when no repeat is allowed).
  int mh, mv, mLives, mState, mDeadCycles, mHold, mPrev;
  bit mBlocked;

  player_mover dut (
    .btnClk(clk), .rst(rst), .btns(btns),
    .upEnable(upEn), .downEnable(downEn), .leftEnable(leftEn), .rightEnable(rightEn),
    .hit(hit), .hPos(hPos), .vPos(vPos), .hOffset(hOffset), .vOffset(vOffset),
    .objWidth(objWidth), .objHeight(objHeight), .color(color), .lives(lives), .status(status)
  );

  always #5 clk = ~clk;

  function automatic int lowestDir(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic modelMove(input int d);
    int nh, nv;
    nh = mh;
    nv = mv;
    case (d)
      0: nv = mv - ST;
      1: nv = mv + ST;
      2: nh = mh - ST;
      default: nh = mh + ST;
    endcase
    if (nh < HMIN) begin nh = HMIN; mBlocked = 1; end
    if (nh > HMAX) begin nh = HMAX; mBlocked = 1; end
    if (nv < VMIN) begin nv = VMIN; mBlocked = 1; end
    if (nv > VMAX) begin nv = VMAX; mBlocked = 1; end
    mh = nh;
    mv = nv;
  endtask

  task automatic modelStep(input logic r_rst, input logic [3:0] r, input logic r_hit);
    int d;
    d = lowestDir(r);
    mBlocked = 0;
    if (r_rst) begin
      mh = HS; mv = VS; mLives = NLIVES; mState = 0; mHold = -1; mDeadCycles = 0;
    end else if (mState == 0) begin
      if (r_hit) begin
        mLives = mLives - 1;
        mh = HS; mv = VS;
        mHold = -1;
        mDeadCycles = 0;
        mState = (mLives == 0) ? 2 : 1;
      end else if (d >= 0 && d != mPrev) begin
        modelMove(d);
        mHold = 0;
      end else if (d >= 0 && mHold >= 0) begin
        mHold = mHold + 1;
        if (mHold >= DLY && ((mHold - DLY) % RATE) == 0) modelMove(d);
      end else begin
        mHold = -1;
      end
    end else if (mState == 1) begin
      mHold = -1;
      mDeadCycles = mDeadCycles + 1;
      if (mDeadCycles == RESP) mState = 0;
    end
    mPrev = d;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep(rst, btns & {rightEn, leftEn, downEn, upEn}, hit);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; btns = 4'd0; hit = 1'b0;
    upEn = 1'b1; downEn = 1'b1; leftEn = 1'b1; rightEn = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    if (hPos !== 12'd308) begin nFail++; $display("FAIL reset_hpos: got %0d want 308", hPos); end
    nChecks++;
    if (vPos !== 12'd372) begin nFail++; $display("FAIL reset_vpos: got %0d want 372", vPos); end
    nChecks++;
    if (hOffset !== 32'd0 || vOffset !== 32'd0) begin
      nFail++; $display("FAIL reset_offsets: got %h/%h want 0/0", hOffset, vOffset);
    end
    nChecks++;
    if (lives !== 3'd3) begin nFail++; $display("FAIL reset_lives: got %0d want 3", lives); end
    nChecks++;
    if (status !== 3'b001) begin nFail++; $display("FAIL reset_status: got %b want 001", status); end
    nChecks++;
    if (color !== 3'b100) begin nFail++; $display("FAIL reset_color: got %b want 100", color); end
    nChecks++;
    if (objWidth !== 12'd12 || objHeight !== 12'd12) begin
      nFail++; $display("FAIL reset_size: got %0d x %0d want 12 x 12", objWidth, objHeight);
    end
    nChecks++;
  endtask

  task automatic test_single_press();
    doReset();
    btns = 4'b0001;
    tick();
    btns = 4'b0000;
    if (vPos !== 12'd360) begin nFail++; $display("FAIL single_vpos: got %0d want 360", vPos); end
    nChecks++;
    if (vOffset !== 32'hFFFF_FFF4) begin nFail++; $display("FAIL single_voff: got %h want fffffff4", vOffset); end
    nChecks++;
    repeat (6) tick();
    if (vPos !== 12'd360 || hPos !== 12'd308) begin
      nFail++; $display("FAIL single_nomore: got %0d,%0d want 308,360", hPos, vPos);
    end
    nChecks++;
  endtask

  task automatic test_hold_repeat();
    int expH;
    doReset();
    btns = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      tick();
      expH = (k < 8) ? 320 : (k < 12) ? 332 : (k < 16) ? 344 : 356;
      if (hPos !== 12'(expH)) begin nFail++; $display("FAIL hold_k%0d: got %0d want %0d", k, hPos, expH); end
      nChecks++;
    end
    btns = 4'b0000;
    repeat (8) tick();
    if (hPos !== 12'd356) begin nFail++; $display("FAIL hold_release: got %0d want 356", hPos); end
    nChecks++;
  endtask

  task automatic test_clamp();
    doReset();
    for (int i = 0; i < 25; i++) begin
      btns = 4'b0100; tick();
      btns = 4'b0000; tick();
    end
    if (hPos !== 12'd8 || status !== 3'b001) begin
      nFail++; $display("FAIL clamp_pre: got h=%0d st=%b want h=8 st=001", hPos, status);
    end
    nChecks++;
    btns = 4'b0100; tick();
    if (hPos !== 12'd0 || status !== 3'b101) begin
      nFail++; $display("FAIL clamp_left: got h=%0d st=%b want h=0 st=101", hPos, status);
    end
    nChecks++;
    btns = 4'b0000; tick();
    if (status !== 3'b001) begin nFail++; $display("FAIL clamp_pulse: got %b want 001", status); end
    nChecks++;
    btns = 4'b0100; tick();
    if (hPos !== 12'd0 || status !== 3'b101) begin
      nFail++; $display("FAIL clamp_again: got h=%0d st=%b want h=0 st=101", hPos, status);
    end
    nChecks++;
    btns = 4'b0000; tick();
    for (int i = 0; i < 8; i++) begin
      btns = 4'b0010; tick();
      btns = 4'b0000; tick();
    end
    if (vPos !== 12'd468 || status !== 3'b001) begin
      nFail++; $display("FAIL clamp_vmax_exact: got v=%0d st=%b want v=468 st=001", vPos, status);
    end
    nChecks++;
    btns = 4'b0010; tick();
    if (vPos !== 12'd468 || status !== 3'b101) begin
      nFail++; $display("FAIL clamp_vmax: got v=%0d st=%b want v=468 st=101", vPos, status);
    end
    nChecks++;
    btns = 4'b0000; tick();
  endtask

  task automatic test_priority();
    doReset();
    btns = 4'b1100; tick();
    if (hPos !== 12'd296 || vPos !== 12'd372) begin
      nFail++; $display("FAIL prio_left: got %0d,%0d want 296,372", hPos, vPos);
    end
    nChecks++;
    btns = 4'b0000; tick();
    rightEn = 1'b0;
    btns = 4'b1000; tick();
    if (hPos !== 12'd296) begin nFail++; $display("FAIL prio_gated: got %0d want 296", hPos); end
    nChecks++;
    rightEn = 1'b1; tick();
    if (hPos !== 12'd308) begin nFail++; $display("FAIL prio_enable_edge: got %0d want 308", hPos); end
    nChecks++;
    btns = 4'b0000; tick();
  endtask

  task automatic test_hit_respawn();
    doReset();
    btns = 4'b0001; hit = 1'b1;
    tick();
    hit = 1'b0;
    if (vPos !== 12'd372 || lives !== 3'd2 || status !== 3'b010 || color !== 3'b000) begin
      nFail++; $display("FAIL hit_first: got v=%0d l=%0d st=%b c=%b want 372 2 010 000", vPos, lives, status, color);
    end
    nChecks++;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (status !== 3'b010 || color !== 3'b000) begin
        nFail++; $display("FAIL hit_dead_k%0d: got st=%b c=%b want 010 000", k, status, color);
      end
      nChecks++;
    end
    tick();
    if (status !== 3'b001 || color !== 3'b100 || hPos !== 12'd308 || vPos !== 12'd372) begin
      nFail++; $display("FAIL hit_respawn: got st=%b c=%b pos=%0d,%0d want 001 100 308,372", status, color, hPos, vPos);
    end
    nChecks++;
    repeat (12) tick();
    if (vPos !== 12'd372) begin nFail++; $display("FAIL hit_held_nomove: got %0d want 372", vPos); end
    nChecks++;
    btns = 4'b0000; tick();
    btns = 4'b0001; tick();
    if (vPos !== 12'd360) begin nFail++; $display("FAIL hit_repress: got %0d want 360", vPos); end
    nChecks++;
    btns = 4'b0000; tick();
  endtask

  task automatic test_gameover();
    doReset();
    for (int i = 0; i < 3; i++) begin
      hit = 1'b1; tick(); hit = 1'b0;
      if (lives !== 3'(2 - i)) begin nFail++; $display("FAIL go_lives_%0d: got %0d want %0d", i, lives, 2 - i); end
      nChecks++;
      if (i < 2) repeat (16) tick();
    end
    if (status !== 3'b000 || color !== 3'b000) begin
      nFail++; $display("FAIL go_state: got st=%b c=%b want 000 000", status, color);
    end
    nChecks++;
    for (int i = 0; i < 10; i++) begin
      btns = 4'($urandom_range(1, 15)); hit = 1'($urandom_range(0, 1)); tick();
    end
    hit = 1'b0;
    if (hPos !== 12'd308 || vPos !== 12'd372 || status !== 3'b000 || lives !== 3'd0) begin
      nFail++; $display("FAIL go_frozen: got %0d,%0d st=%b l=%0d", hPos, vPos, status, lives);
    end
    nChecks++;
    btns = 4'b0000; rst = 1'b1; tick(); rst = 1'b0;
    if (lives !== 3'd3 || status !== 3'b001 || color !== 3'b100) begin
      nFail++; $display("FAIL go_rst: got l=%0d st=%b c=%b want 3 001 100", lives, status, color);
    end
    nChecks++;
    // reset in the middle of a respawn wait
    hit = 1'b1; tick(); hit = 1'b0;
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    if (lives !== 3'd3 || status !== 3'b001) begin
      nFail++; $display("FAIL dead_rst: got l=%0d st=%b want 3 001", lives, status);
    end
    nChecks++;
  endtask

  task automatic test_held_through_reset();
    btns = 4'b0001; rst = 1'b1; tick(); rst = 1'b0;
    repeat (12) tick();
    if (vPos !== 12'd372) begin nFail++; $display("FAIL rst_held: got %0d want 372", vPos); end
    nChecks++;
    btns = 4'b0000; tick();
    btns = 4'b0001; tick();
    if (vPos !== 12'd360) begin nFail++; $display("FAIL rst_held_repress: got %0d want 360", vPos); end
    nChecks++;
    btns = 4'b0000; tick();
  endtask

  task automatic test_random();
    logic [2:0] expStatus, expColor;
    int pick;
    doReset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        pick = $urandom_range(0, 6);
        btns = (pick < 4) ? 4'(1 << pick) : (pick == 4) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) {rightEn, leftEn, downEn, upEn} = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) == 0) {rightEn, leftEn, downEn, upEn} = 4'hF;
      hit = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
      expStatus = (mState == 0) ? {mBlocked, 2'b01} : (mState == 1) ? 3'b010 : 3'b000;
      expColor  = (mState == 0) ? 3'b100 : 3'b000;
      if (hPos !== 12'(mh) || vPos !== 12'(mv)) begin
        nFail++; $display("FAIL rand_pos c=%0d: got %0d,%0d want %0d,%0d", c, hPos, vPos, mh, mv);
      end
      nChecks++;
      if (hOffset !== 32'(mh - HS) || vOffset !== 32'(mv - VS)) begin
        nFail++; $display("FAIL rand_off c=%0d: got %h,%h want %h,%h", c, hOffset, vOffset, 32'(mh - HS), 32'(mv - VS));
      end
      nChecks++;
      if (status !== expStatus || color !== expColor || lives !== 3'(mLives)) begin
        nFail++; $display("FAIL rand_state c=%0d: got st=%b c=%b l=%0d want st=%b c=%b l=%0d",
                          c, status, color, lives, expStatus, expColor, mLives);
      end
      nChecks++;
    end
    rst = 1'b0; hit = 1'b0; btns = 4'd0;
  endtask

  initial begin
    mPrev = -1;
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_clamp();
    test_priority();
    test_hit_respawn();
    test_gameover();
    test_held_through_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
